// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one bin2bcd converter among NREQ requesters.
// Optional build macro BCD_BLANK_EN blanks leading zero digits with 4'hF.
module bcd_conv_arbiter #(
    parameter int NREQ        = 2,
    parameter int W           = 16,
    parameter int CONV_CYCLES = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_val,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      conv_in,
    output logic              strt_bcd,
    input  logic [3:0]        bcd_ones,
    input  logic [3:0]        bcd_tens,
    input  logic [3:0]        bcd_hundreds,
    input  logic [3:0]        bcd_thousands,
    output logic [NREQ-1:0]   done,
    output logic [15:0]       digits_out,
    output logic              ovf,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(CONV_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        CAPTURE
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     own_q, own_d;
    logic              oor_q, oor_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [W-1:0]      conv_q, conv_d;
    logic              strt_q, strt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [15:0]       dig_q, dig_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;

    logic              found;
    logic [PW-1:0]     sel_idx;
    logic [PW-1:0]     idx_v;
    logic [W-1:0]      sel_val;
    logic              sel_oor;
    logic [15:0]       raw;
    logic [15:0]       cap;

    // Search starts just after the last owner so every requester gets a turn.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        idx_v   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_v = PW'((int'(ptr_q) + k) % NREQ);
            if (!found && req[idx_v]) begin
                found   = 1'b1;
                sel_idx = idx_v;
            end
        end
    end

    assign sel_val = req_val[int'(sel_idx)*W +: W];
    assign sel_oor = (32'(sel_val) > 32'd9999);
    assign raw     = {bcd_thousands, bcd_hundreds, bcd_tens, bcd_ones};

`ifdef BCD_BLANK_EN
    always_comb begin
        cap = raw;
        if (raw[15:12] == 4'h0) begin
            cap[15:12] = 4'hF;
            if (raw[11:8] == 4'h0) begin
                cap[11:8] = 4'hF;
                if (raw[7:4] == 4'h0) begin
                    cap[7:4] = 4'hF;
                end
            end
        end
    end
`else
    assign cap = raw;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        oor_d   = oor_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        conv_d  = conv_q;
        strt_d  = 1'b0;
        done_d  = '0;
        dig_d   = dig_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d        = START;
                    own_d          = sel_idx;
                    oor_d          = sel_oor;
                    conv_d         = sel_val;
                    gnt_d[sel_idx] = 1'b1;
                    strt_d         = !sel_oor;
                end
            end
            START: begin
                ptr_d = own_q;
                if (oor_q) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CW'(CONV_CYCLES - 1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CAPTURE: begin
                state_d       = IDLE;
                done_d[own_q] = 1'b1;
                if (oor_q) begin
                    dig_d = 16'h9999;
                    ovf_d = 1'b1;
                end else begin
                    dig_d = cap;
                    ovf_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NREQ - 1);
            own_q   <= '0;
            oor_q   <= 1'b0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            conv_q  <= '0;
            strt_q  <= 1'b0;
            done_q  <= '0;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            oor_q   <= oor_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            conv_q  <= conv_d;
            strt_q  <= strt_d;
            done_q  <= done_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt        = gnt_q;
    assign conv_in    = conv_q;
    assign strt_bcd   = strt_q;
    assign done       = done_q;
    assign digits_out = dig_q;
    assign ovf        = ovf_q;
    assign busy       = busy_q;

endmodule
